// File: rtl/stopwatch_ctrl_if.sv
// Control pulses in, display digits and status out, between the stopwatch
// sequencer and its environment.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] disp_s0;
  logic [3:0] disp_s1;
  logic [3:0] disp_m0;
  logic [3:0] disp_m1;
  logic       running;
  logic       lap_hold;
  logic       wrap;

  modport master (
    output start_stop, clear, lap,
    input  disp_s0, disp_s1, disp_m0, disp_m1, running, lap_hold, wrap
  );

  modport slave (
    input  start_stop, clear, lap,
    output disp_s0, disp_s1, disp_m0, disp_m1, running, lap_hold, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/clear FSM, 1 Hz prescaler, MM:SS digit
// cascade of limited incrementors, and a lap freeze of the displayed value.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned PRE_W    = 27
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

  // Digit stays within 0..lim-1, so carry-out only happens on carry-in at lim-1.
  function automatic logic [4:0] lim_inc(input logic [3:0] d, input logic ci,
                                         input logic [3:0] lim);
    logic [4:0] r;
    if (ci && (d == (lim - 4'd1))) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + {3'd0, ci}};
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      live_q, live_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      disp_q;
  logic             hold_q, hold_d;
  logic             running_q;
  logic             wrap_q;
  logic             tick_s;
  logic [4:0]       inc_s0_s, inc_s1_s, inc_m0_s, inc_m1_s;
  logic [15:0]      live_inc_s;

  assign tick_s     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign inc_s0_s   = lim_inc(live_q[3:0],   tick_s,      4'd10);
  assign inc_s1_s   = lim_inc(live_q[7:4],   inc_s0_s[4], 4'd6);
  assign inc_m0_s   = lim_inc(live_q[11:8],  inc_s1_s[4], 4'd10);
  assign inc_m1_s   = lim_inc(live_q[15:12], inc_m0_s[4], 4'd6);
  assign live_inc_s = {inc_m1_s[3:0], inc_m0_s[3:0], inc_s1_s[3:0], inc_s0_s[3:0]};

  // Next-state decode; clear > start_stop > lap, illegal pulses fall through.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    live_d  = live_inc_s;
    snap_d  = snap_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (sw.start_stop) begin
          state_d = ST_RUN;
          pre_d   = {PRE_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          pre_d = {PRE_W{1'b0}};
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        if (sw.start_stop) begin
          state_d = ST_PAUSE;
        end else if (sw.lap) begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            hold_d = 1'b1;
            snap_d = live_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (sw.clear) begin
          state_d = ST_IDLE;
          live_d  = 16'd0;
          pre_d   = {PRE_W{1'b0}};
          hold_d  = 1'b0;
        end else if (sw.start_stop) begin
          state_d = ST_RUN;
        end else if (sw.lap) begin
          hold_d = 1'b0;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pre_d   = {PRE_W{1'b0}};
        live_d  = 16'd0;
        hold_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= {PRE_W{1'b0}};
      live_q    <= 16'd0;
      snap_q    <= 16'd0;
      hold_q    <= 1'b0;
      disp_q    <= 16'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      live_q    <= live_d;
      snap_q    <= snap_d;
      hold_q    <= hold_d;
      disp_q    <= hold_d ? snap_d : live_d;
      running_q <= (state_d == ST_RUN);
      wrap_q    <= inc_m1_s[4];
    end
  end

  assign sw.disp_s0  = disp_q[3:0];
  assign sw.disp_s1  = disp_q[7:4];
  assign sw.disp_m0  = disp_q[11:8];
  assign sw.disp_m1  = disp_q[15:12];
  assign sw.running  = running_q;
  assign sw.lap_hold = hold_q;
  assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a seconds-count reference model pushes
// the expected outputs per cycle, a monitor pops and compares after each edge.
module tb_stopwatch_ctrl;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic        running;
    logic        hold;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: total elapsed seconds plus sub-second phase.
  bit m_run, m_pause, m_hold, m_wrap;
  int m_phase, m_sec, m_snap;

  function automatic logic [15:0] digits(input int s);
    logic [15:0] r;
    r[3:0]   = 4'(s % 10);
    r[7:4]   = 4'((s / 10) % 6);
    r[11:8]  = 4'((s / 60) % 10);
    r[15:12] = 4'((s / 600) % 6);
    return r;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.disp    = digits(m_hold ? m_snap : m_sec);
    e.running = m_run;
    e.hold    = m_hold;
    e.wrap    = m_wrap;
    return e;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_hold = 0; m_wrap = 0;
    m_phase = 0; m_sec = 0; m_snap = 0;
  endtask

  task automatic model_step(input bit ss, input bit cl, input bit lp);
    bit tick;
    int old_sec;
    tick    = m_run && (m_phase == TD - 1);
    m_wrap  = tick && (m_sec == 3599);
    old_sec = m_sec;
    if (tick) m_sec = (m_sec + 1) % 3600;
    if (m_run) m_phase = tick ? 0 : m_phase + 1;
    if (!m_run && !m_pause) begin
      if (ss) begin m_run = 1; m_phase = 0; end
    end else if (m_run) begin
      if (ss) begin
        m_run = 0; m_pause = 1;
      end else if (lp) begin
        if (m_hold) m_hold = 0;
        else begin m_hold = 1; m_snap = old_sec; end
      end
    end else begin
      if (cl) begin
        m_pause = 0; m_sec = 0; m_phase = 0; m_hold = 0;
      end else if (ss) begin
        m_pause = 0; m_run = 1;
      end else if (lp) begin
        m_hold = 0;
      end
    end
  endtask

  function automatic exp_t dut_out();
    exp_t e;
    e.disp    = {sw_if.disp_m1, sw_if.disp_m0, sw_if.disp_s1, sw_if.disp_s0};
    e.running = sw_if.running;
    e.hold    = sw_if.lap_hold;
    e.wrap    = sw_if.wrap;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a = dut_out();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t: got disp=%h run=%b hold=%b wrap=%b, expected disp=%h run=%b hold=%b wrap=%b",
               name, $time, a.disp, a.running, a.hold, a.wrap,
               e.disp, e.running, e.hold, e.wrap);
    end
  endtask

  task automatic step(input bit ss, input bit cl, input bit lp);
    @(negedge clk);
    sw_if.start_stop = ss;
    sw_if.clear      = cl;
    sw_if.lap        = lp;
    if (!rst_n) model_reset();
    else model_step(ss, cl, lp);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_reset", model_out());
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) compare("scoreboard", exp_q.pop_front());
    end
  end

  initial begin : stimulus
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset mid-run at 00:03, then restart latency.
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    async_reset();
    idle(3);
    rst_n = 1'b1;
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    idle(6);

    // Pause keeps the fractional second.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(20);
    step(1'b1, 1'b0, 1'b0);
    idle(6);

    // Lap freeze at 00:05 while live count runs on.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(20);
    step(1'b0, 1'b0, 1'b1);
    idle(12);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // Priority cases.
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b1);
    idle(5);

    // Clear while frozen, then restart from 00:00.
    step(1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(9);

    // Full hour from 00:00: 00:09->00:10, 09:59->10:00, 59:59->00:00 wrap.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3600 * TD + 10);

    // Random pulse mix, including coincident pulses.
    repeat (4000) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0);
    end
    idle(2);

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
